// File: rtl/normalizer_pkg.sv
// Shared types and helpers for the normalizer pipeline.
// The S2 payload struct is sized for the widest supported configuration
// (DATA_WIDTH <= MAX_DATA_WIDTH, EXP_WIDTH <= MAX_EXP_WIDTH). Narrower
// builds zero-extend into it and slice back out at the ports.
package normalizer_pkg;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_EXP_WIDTH  = 32;

  // Width needed to hold a shift/count in 0..data_width inclusive.
  function automatic int shift_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  localparam int MAX_SHIFT_WIDTH = shift_width(MAX_DATA_WIDTH);

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0]  data;
    logic [MAX_EXP_WIDTH-1:0]   exp;
    logic [MAX_SHIFT_WIDTH-1:0] shift;
    logic                       zero;
    logic                       uf;
  } s2_payload_t;

endpackage

// File: rtl/normalizer_leading_zeros.sv
// Leading-zero counter: number of zeros above the most significant 1.
// An all-zero input reports WIDTH.
module leading_zeros #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0]     i_data,
  output logic [CNT_WIDTH-1:0] o_count
);

  // Scan LSB to MSB so the highest set bit determines the final count.
  always_comb begin
    o_count = CNT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) begin
        o_count = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/normalizer.sv
// Two-stage mantissa normalizer with valid/ready handshakes.
// S1 captures the input beat together with its leading-zero count;
// S2 holds the shifted mantissa, adjusted exponent and flags.
// Optional feature: define NORMALIZER_UNDERFLOW_EN to limit the shift to the
// input exponent (exponent clamps at 0 and out_uf flags it). Without it the
// exponent simply wraps.
module normalizer
  import normalizer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int EXP_WIDTH   = 8,
  localparam int SHIFT_WIDTH = shift_width(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [EXP_WIDTH-1:0]   in_exp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [EXP_WIDTH-1:0]   out_exp,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_zero,
  output logic                   out_uf
);

  logic                   r_s1_valid;
  logic [DATA_WIDTH-1:0]  r_s1_data;
  logic [EXP_WIDTH-1:0]   r_s1_exp;
  logic [SHIFT_WIDTH-1:0] r_s1_cnt;

  logic                   r_s2_valid;
  s2_payload_t            r_s2_payload;

  logic                   w_s2_ready;
  logic                   w_in_ready;
  logic [SHIFT_WIDTH-1:0] w_cnt;
  logic [SHIFT_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [EXP_WIDTH-1:0]   w_exp;
  logic                   w_zero;
  logic                   w_uf;
  s2_payload_t            w_s2_payload;

  // Ready ripples back combinationally: a stage can load if it is empty or
  // the stage after it is draining this cycle.
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_in_ready;

  leading_zeros #(
    .WIDTH     (DATA_WIDTH),
    .CNT_WIDTH (SHIFT_WIDTH)
  ) u_lzc (
    .i_data  (in_data),
    .o_count (w_cnt)
  );

  // S1: capture the accepted beat and its leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_exp   <= '0;
      r_s1_cnt   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_exp  <= in_exp;
        r_s1_cnt  <= w_cnt;
      end
    end
  end

  // Shift amount, shifted mantissa, exponent adjustment and flags from S1.
  always_comb begin
    w_zero  = (r_s1_cnt == SHIFT_WIDTH'(DATA_WIDTH));
    w_shift = r_s1_cnt;
    w_uf    = 1'b0;
`ifdef NORMALIZER_UNDERFLOW_EN
    // Shifting by more than the exponent would drive it negative; stop at 0.
    if (!w_zero && (32'(r_s1_cnt) > 32'(r_s1_exp))) begin
      w_shift = SHIFT_WIDTH'(r_s1_exp);
      w_uf    = 1'b1;
    end
`endif
    w_data = r_s1_data << w_shift;
    w_exp  = r_s1_exp - EXP_WIDTH'(w_shift);
    if (w_zero) begin
      w_exp = '0;
    end
    w_s2_payload       = '0;
    w_s2_payload.data  = MAX_DATA_WIDTH'(w_data);
    w_s2_payload.exp   = MAX_EXP_WIDTH'(w_exp);
    w_s2_payload.shift = MAX_SHIFT_WIDTH'(w_shift);
    w_s2_payload.zero  = w_zero;
    w_s2_payload.uf    = w_uf;
  end

  // S2: register the result; hold it while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_payload <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_payload <= w_s2_payload;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_payload.data[DATA_WIDTH-1:0];
  assign out_exp   = r_s2_payload.exp[EXP_WIDTH-1:0];
  assign out_shift = r_s2_payload.shift[SHIFT_WIDTH-1:0];
  assign out_zero  = r_s2_payload.zero;
  assign out_uf    = r_s2_payload.uf;

endmodule

// File: tb/tb_normalizer.sv
// Directed testbench for normalizer (DATA_WIDTH=8, EXP_WIDTH=8).
// Expected values follow NORMALIZER_UNDERFLOW_EN when it is defined.
module tb_normalizer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_exp;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_exp;
  logic [3:0] out_shift;
  logic       out_zero;
  logic       out_uf;

  int n_checks = 0;
  int n_fail   = 0;

  // {valid, data, exp, shift, zero, uf}
  logic [22:0] obs;
  assign obs = {out_valid, out_data, out_exp, out_shift, out_zero, out_uf};

  normalizer #(
    .DATA_WIDTH (8),
    .EXP_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_exp   (out_exp),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_uf    (out_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one beat with out_ready high; report acceptance, out_valid one
  // cycle after acceptance, and the output vector two cycles after.
  task automatic send_one(input logic [7:0] d, input logic [7:0] e,
                          output logic acc, output logic early_v,
                          output logic [22:0] res);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_exp    = e;
    #1;
    acc = in_ready;
    tick();
    in_valid = 1'b0;
    early_v  = out_valid;
    tick();
    res = obs;
    $display("beat in=%h exp=%0d -> out=%h exp=%h shift=%0d zero=%b uf=%b",
             d, e, out_data, out_exp, out_shift, out_zero, out_uf);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_checks++;
    if (obs !== 23'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs, 23'h0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_basic();
    logic acc, early_v;
    logic [22:0] res;
    send_one(8'h10, 8'd10, acc, early_v, res);
    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_accept: got %b want 1", acc);
    end
    n_checks++;
    if (early_v !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid after 1 cycle got %b want 0", early_v);
    end
    n_checks++;
    if (res !== {1'b1, 8'h80, 8'd7, 4'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got %h want %h", res, {1'b1, 8'h80, 8'd7, 4'd3, 1'b0, 1'b0});
    end
    tick();
  endtask

  task automatic test_zero();
    logic acc, early_v;
    logic [22:0] res;
    send_one(8'h00, 8'd5, acc, early_v, res);
    n_checks++;
    if (res !== {1'b1, 8'h00, 8'd0, 4'd8, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_result: got %h want %h", res, {1'b1, 8'h00, 8'd0, 4'd8, 1'b1, 1'b0});
    end
    tick();
  endtask

  task automatic test_underflow();
    logic acc, early_v;
    logic [22:0] res;
    logic [22:0] exp_res;
`ifdef NORMALIZER_UNDERFLOW_EN
    exp_res = {1'b1, 8'h08, 8'h00, 4'd3, 1'b0, 1'b1};
`else
    exp_res = {1'b1, 8'h80, 8'hFC, 4'd7, 1'b0, 1'b0};
`endif
    send_one(8'h01, 8'd3, acc, early_v, res);
    n_checks++;
    if (res !== exp_res) begin
      n_fail++;
      $display("FAIL underflow_result: got %h want %h", res, exp_res);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  beats [4];
    logic [22:0] want  [4];
    beats = '{8'h01, 8'h02, 8'h40, 8'h80};
    want  = '{{1'b1, 8'h80, 8'd13, 4'd7, 1'b0, 1'b0},
              {1'b1, 8'h80, 8'd14, 4'd6, 1'b0, 1'b0},
              {1'b1, 8'h80, 8'd19, 4'd1, 1'b0, 1'b0},
              {1'b1, 8'h80, 8'd20, 4'd0, 1'b0, 1'b0}};
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        in_valid = 1'b1;
        in_data  = beats[c];
        in_exp   = 8'd20;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready[%0d]: got %b want 1", c, in_ready);
        end
      end else begin
        in_valid = 1'b0;
        #1;
      end
      if (c >= 2 && c < 6) begin
        $display("b2b result %0d: %h", c - 2, obs);
        n_checks++;
        if (obs !== want[c-2]) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got %h want %h", c - 2, obs, want[c-2]);
        end
      end else if (c == 6) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle: out_valid got %b want 0", out_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [22:0] wa, wb, wc;
    wa = {1'b1, 8'hC0, 8'd3, 4'd6, 1'b0, 1'b0};
    wb = {1'b1, 8'h80, 8'd7, 4'd2, 1'b0, 1'b0};
    wc = {1'b1, 8'hFE, 8'd8, 4'd1, 1'b0, 1'b0};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h03;
    in_exp    = 8'd9;
    tick();                          // A accepted
    in_data = 8'h20;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ready_b: got %b want 1", in_ready);
    end
    tick();                          // A -> S2, B -> S1
    in_data = 8'h7F;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ready_full: got %b want 0", in_ready);
    end
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (obs !== wa) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h want %h", s, obs, wa);
      end
      if (s < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    tick();                          // A out, B -> S2, C accepted
    in_valid = 1'b0;
    $display("stall result B: %h", obs);
    n_checks++;
    if (obs !== wb) begin
      n_fail++;
      $display("FAIL stall_order_b: got %h want %h", obs, wb);
    end
    tick();
    $display("stall result C: %h", obs);
    n_checks++;
    if (obs !== wc) begin
      n_fail++;
      $display("FAIL stall_order_c: got %h want %h", obs, wc);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_dup: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h10;
    in_exp    = 8'd10;
    tick();
    in_data = 8'h01;
    in_exp  = 8'd20;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 8'h80, 8'd7, 4'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_inflight: got %h want %h", obs, {1'b1, 8'h80, 8'd7, 4'd3, 1'b0, 1'b0});
    end
    #3;
    rst_n = 1'b0;                    // between clock edges
    #1;
    $display("async reset asserted: out_valid=%b in_ready=%b", out_valid, in_ready);
    n_checks++;
    if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL midrst_async: got valid=%b ready=%b data=%h want 0 1 00",
               out_valid, in_ready, out_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_no_result[%0d]: out_valid got %b want 0", c, out_valid);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_exp    = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_underflow();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
